// File: rtl/character_motion_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : character_motion_pkg                                         |
// | Description : Shared motion-state encodings and collision bit indices.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

package character_motion_pkg;

  typedef enum logic [1:0] {
    MS_GROUND = 2'd0,
    MS_RISE   = 2'd1,
    MS_FALL   = 2'd2
  } mstate_t;

  localparam int COLL_CEIL   = 0;
  localparam int COLL_GROUND = 1;
  localparam int COLL_RIGHT  = 2;
  localparam int COLL_LEFT   = 3;

endpackage

`default_nettype wire

// File: rtl/character_motion_sat_step.sv
// +----------------------------------------------------------------------------+
// | Module      : character_motion_sat_step                                    |
// | Description : Signed add with one guard bit, clamped to [lo, hi].          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module character_motion_sat_step #(
  parameter int W = 8
) (
  input  logic signed [W:0] a,
  input  logic signed [W:0] b,
  input  logic signed [W:0] lo,
  input  logic signed [W:0] hi,
  output logic signed [W:0] y
);

  logic signed [W+1:0] w_sum;
  logic signed [W+1:0] w_lo;
  logic signed [W+1:0] w_hi;

  always_comb begin
    w_sum = (W+2)'(a) + (W+2)'(b);
    w_lo  = (W+2)'(lo);
    w_hi  = (W+2)'(hi);
    if (w_sum < w_lo) begin
      y = lo;
    end else if (w_sum > w_hi) begin
      y = hi;
    end else begin
      y = w_sum[W:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/character_motion.sv
// +----------------------------------------------------------------------------+
// | Module      : character_motion                                             |
// | Description : Per-character position/velocity engine, one step per tick.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module character_motion
  import character_motion_pkg::*;
#(
  parameter int X_W          = 10,
  parameter int Y_W          = 9,
  parameter int V_W          = 6,
  parameter int X_MAX        = 639,
  parameter int Y_MAX        = 479,
  parameter int RESET_X      = 32,
  parameter int RESET_Y      = 400,
  parameter int H_SPEED      = 1,
  parameter int GRAVITY      = 1,
  parameter int JUMP_VEL     = 6,
  parameter int MAX_FALL     = 8,
  parameter int COYOTE_TICKS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  spawn,
  input  logic [X_W-1:0]        spawn_x,
  input  logic [Y_W-1:0]        spawn_y,
  input  logic                  key_up,
  input  logic                  key_left,
  input  logic                  key_right,
  input  logic [3:0]            coll,
  output logic [X_W-1:0]        pos_x,
  output logic [Y_W-1:0]        pos_y,
  output logic signed [V_W-1:0] vel_y,
  output logic [1:0]            mstate,
  output logic                  facing_left,
  output logic                  walking
);

  localparam int C_W = $clog2(COYOTE_TICKS + 1);

  localparam logic signed [X_W:0] c_X_LO     = '0;
  localparam logic signed [X_W:0] c_X_HI     = (X_W+1)'(X_MAX);
  localparam logic signed [X_W:0] c_H_STEP   = (X_W+1)'(H_SPEED);
  localparam logic signed [Y_W:0] c_Y_LO     = '0;
  localparam logic signed [Y_W:0] c_Y_HI     = (Y_W+1)'(Y_MAX);
  localparam logic signed [V_W:0] c_V_LO     = -((V_W+1)'(MAX_FALL));
  localparam logic signed [V_W:0] c_V_HI     = (V_W+1)'((2 ** (V_W - 1)) - 1);
  localparam logic signed [V_W:0] c_NEG_GRAV = -((V_W+1)'(GRAVITY));
  localparam logic signed [V_W:0] c_JUMP     = (V_W+1)'(JUMP_VEL);
  localparam logic [C_W-1:0]      c_COYOTE   = C_W'(COYOTE_TICKS);

  logic [X_W-1:0]        r_pos_x;
  logic [Y_W-1:0]        r_pos_y;
  logic signed [V_W-1:0] r_vel_y;
  mstate_t               r_ms;
  mstate_t               w_ms_next;
  logic [C_W-1:0]        r_coy;
  logic [C_W-1:0]        w_coy_next;
  logic                  r_facing_left;
  logic                  r_walking;

  logic signed [X_W:0]   w_x_cur;
  logic signed [X_W:0]   w_x_step;
  logic signed [X_W:0]   w_x_next;
  logic                  w_walk;
  logic signed [V_W:0]   w_vel_dec;
  logic signed [V_W:0]   w_vel_next;
  logic signed [Y_W:0]   w_y_step;
  logic signed [Y_W:0]   w_y_next;
  logic                  w_y_unused;

  // Horizontal: left wins over right; a blocked key still sets facing.
  always_comb begin
    w_x_step = '0;
    if (key_left) begin
      if (!coll[COLL_LEFT]) w_x_step = -c_H_STEP;
    end else if (key_right && !coll[COLL_RIGHT]) begin
      w_x_step = c_H_STEP;
    end
  end

  assign w_x_cur = $signed({1'b0, r_pos_x});

  character_motion_sat_step #(.W(X_W)) u_x_step (
    .a  (w_x_cur),
    .b  (w_x_step),
    .lo (c_X_LO),
    .hi (c_X_HI),
    .y  (w_x_next)
  );

  assign w_walk = (key_left || key_right) && (w_x_next != w_x_cur);

  character_motion_sat_step #(.W(V_W)) u_v_step (
    .a  ((V_W+1)'(r_vel_y)),
    .b  (c_NEG_GRAV),
    .lo (c_V_LO),
    .hi (c_V_HI),
    .y  (w_vel_dec)
  );

  always_comb begin
    w_ms_next  = r_ms;
    w_vel_next = '0;
    w_coy_next = r_coy;
    unique case (r_ms)
      MS_GROUND: begin
        if (key_up) begin
          w_vel_next = c_JUMP;
          w_ms_next  = MS_RISE;
          w_coy_next = '0;
        end else if (!coll[COLL_GROUND]) begin
          w_vel_next = c_NEG_GRAV;
          w_ms_next  = MS_FALL;
          w_coy_next = c_COYOTE;
        end
      end
      MS_RISE: begin
        if (coll[COLL_CEIL] || !key_up) begin
          w_ms_next = MS_FALL;
        end else begin
          w_vel_next = w_vel_dec;
          if (w_vel_dec[V_W] || (w_vel_dec == '0)) w_ms_next = MS_FALL;
        end
      end
      MS_FALL: begin
        if (coll[COLL_GROUND]) begin
          w_ms_next  = MS_GROUND;
          w_coy_next = '0;
        end else if (key_up && (r_coy != '0)) begin
          w_vel_next = c_JUMP;
          w_ms_next  = MS_RISE;
          w_coy_next = '0;
        end else begin
          w_vel_next = w_vel_dec;
          if (r_coy != '0) w_coy_next = r_coy - 1'b1;
        end
      end
      default: begin
        w_ms_next = MS_FALL;
      end
    endcase
  end

  // Screen y grows downward, so upward velocity subtracts.
  assign w_y_step = -((Y_W+1)'(w_vel_next));

  character_motion_sat_step #(.W(Y_W)) u_y_step (
    .a  ($signed({1'b0, r_pos_y})),
    .b  (w_y_step),
    .lo (c_Y_LO),
    .hi (c_Y_HI),
    .y  (w_y_next)
  );

  assign w_y_unused = w_y_next[Y_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos_x       <= X_W'(RESET_X);
      r_pos_y       <= Y_W'(RESET_Y);
      r_vel_y       <= '0;
      r_ms          <= MS_FALL;
      r_coy         <= '0;
      r_facing_left <= 1'b0;
      r_walking     <= 1'b0;
    end else if (spawn) begin
      r_pos_x   <= spawn_x;
      r_pos_y   <= spawn_y;
      r_vel_y   <= '0;
      r_ms      <= MS_FALL;
      r_coy     <= '0;
      r_walking <= 1'b0;
    end else if (tick) begin
      r_pos_x   <= w_x_next[X_W-1:0];
      r_pos_y   <= w_y_next[Y_W-1:0];
      r_vel_y   <= w_vel_next[V_W-1:0];
      r_ms      <= w_ms_next;
      r_coy     <= w_coy_next;
      r_walking <= w_walk;
      if (key_left) begin
        r_facing_left <= 1'b1;
      end else if (key_right) begin
        r_facing_left <= 1'b0;
      end
    end
  end

  assign pos_x       = r_pos_x;
  assign pos_y       = r_pos_y;
  assign vel_y       = r_vel_y;
  assign mstate      = r_ms;
  assign facing_left = r_facing_left;
  assign walking     = r_walking;

endmodule

`default_nettype wire

// File: tb/tb_character_motion.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_character_motion                                          |
// | Description : Scoreboard bench for character_motion.                       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_character_motion;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic        spawn;
  logic [9:0]  spawn_x;
  logic [8:0]  spawn_y;
  logic        key_up;
  logic        key_left;
  logic        key_right;
  logic [3:0]  coll;
  logic [9:0]  pos_x;
  logic [8:0]  pos_y;
  logic [5:0]  vel_y;
  logic [1:0]  mstate;
  logic        facing_left;
  logic        walking;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string tag;
    int    x;
    int    y;
    int    v;
    int    ms;
    int    fl;
    int    wk;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  character_motion u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .spawn       (spawn),
    .spawn_x     (spawn_x),
    .spawn_y     (spawn_y),
    .key_up      (key_up),
    .key_left    (key_left),
    .key_right   (key_right),
    .coll        (coll),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .vel_y       (vel_y),
    .mstate      (mstate),
    .facing_left (facing_left),
    .walking     (walking)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    check($sformatf("%s.x", e.tag),  int'(pos_x),           e.x);
    check($sformatf("%s.y", e.tag),  int'(pos_y),           e.y);
    check($sformatf("%s.v", e.tag),  int'($signed(vel_y)),  e.v);
    check($sformatf("%s.ms", e.tag), int'(mstate),          e.ms);
    check($sformatf("%s.fl", e.tag), int'(facing_left),     e.fl);
    check($sformatf("%s.wk", e.tag), int'(walking),         e.wk);
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input string tag, input bit tk, input bit sp,
                      input int sx, input int sy,
                      input bit up, input bit l, input bit r, input logic [3:0] c,
                      input int ex, input int ey, input int ev,
                      input int ems, input int efl, input int ewk);
    exp_t e;
    @(negedge clk);
    tick      = tk;
    spawn     = sp;
    spawn_x   = 10'(sx);
    spawn_y   = 9'(sy);
    key_up    = up;
    key_left  = l;
    key_right = r;
    coll      = c;
    e = '{tag: tag, x: ex, y: ey, v: ev, ms: ems, fl: efl, wk: ewk};
    sb.push_back(e);
    @(negedge clk);
    tick  = 1'b0;
    spawn = 1'b0;
    if (sb.size() == 0) begin
      check("sb_underflow", 0, 1);
    end else begin
      check_outputs(sb.pop_front());
    end
  endtask

  initial begin
    int y;
    int v;
    exp_t e;

    rst_n = 1'b0; tick = 1'b0; spawn = 1'b0; spawn_x = '0; spawn_y = '0;
    key_up = 1'b0; key_left = 1'b0; key_right = 1'b0; coll = '0;
    repeat (2) @(negedge clk);
    e = '{tag: "reset", x: 32, y: 400, v: 0, ms: 2, fl: 0, wk: 0};
    check_outputs(e);
    rst_n = 1'b1;

    // Land from reset
    step("land1", 1, 0, 0, 0, 0, 0, 0, 4'b0010, 32, 400, 0, 0, 0, 0);
    step("land2", 1, 0, 0, 0, 0, 0, 0, 4'b0010, 32, 400, 0, 0, 0, 0);

    // Full jump arc with key held
    step("j_spawn", 0, 1, 100, 200, 0, 0, 0, 4'b0000, 100, 200, 0, 2, 0, 0);
    step("j_gnd",   1, 0, 0, 0, 0, 0, 0, 4'b0010, 100, 200, 0, 0, 0, 0);
    step("j1", 1, 0, 0, 0, 1, 0, 0, 4'b0000, 100, 194, 6, 1, 0, 0);
    step("j2", 1, 0, 0, 0, 1, 0, 0, 4'b0000, 100, 189, 5, 1, 0, 0);
    step("j3", 1, 0, 0, 0, 1, 0, 0, 4'b0000, 100, 185, 4, 1, 0, 0);
    step("j4", 1, 0, 0, 0, 1, 0, 0, 4'b0000, 100, 182, 3, 1, 0, 0);
    step("j5", 1, 0, 0, 0, 1, 0, 0, 4'b0000, 100, 180, 2, 1, 0, 0);
    step("j6", 1, 0, 0, 0, 1, 0, 0, 4'b0000, 100, 179, 1, 1, 0, 0);
    step("j7", 1, 0, 0, 0, 1, 0, 0, 4'b0000, 100, 179, 0, 2, 0, 0);

    // Ceiling bump at vel 4
    step("c_spawn", 0, 1, 100, 200, 0, 0, 0, 4'b0000, 100, 200, 0, 2, 0, 0);
    step("c_gnd",   1, 0, 0, 0, 0, 0, 0, 4'b0010, 100, 200, 0, 0, 0, 0);
    step("c1", 1, 0, 0, 0, 1, 0, 0, 4'b0000, 100, 194, 6, 1, 0, 0);
    step("c2", 1, 0, 0, 0, 1, 0, 0, 4'b0000, 100, 189, 5, 1, 0, 0);
    step("c3", 1, 0, 0, 0, 1, 0, 0, 4'b0000, 100, 185, 4, 1, 0, 0);
    step("c_hit",  1, 0, 0, 0, 1, 0, 0, 4'b0001, 100, 185, 0, 2, 0, 0);
    step("c_fall", 1, 0, 0, 0, 0, 0, 0, 4'b0000, 100, 186, -1, 2, 0, 0);

    // Coyote jump accepted two ticks after walking off
    step("k_spawn", 0, 1, 100, 200, 0, 0, 0, 4'b0000, 100, 200, 0, 2, 0, 0);
    step("k_gnd",   1, 0, 0, 0, 0, 0, 0, 4'b0010, 100, 200, 0, 0, 0, 0);
    step("k_n0", 1, 0, 0, 0, 0, 0, 0, 4'b0000, 100, 201, -1, 2, 0, 0);
    step("k_n1", 1, 0, 0, 0, 0, 0, 0, 4'b0000, 100, 203, -2, 2, 0, 0);
    step("k_n2", 1, 0, 0, 0, 1, 0, 0, 4'b0000, 100, 197, 6, 1, 0, 0);

    // Coyote window expired at N+4
    step("q_spawn", 0, 1, 100, 200, 0, 0, 0, 4'b0000, 100, 200, 0, 2, 0, 0);
    step("q_gnd",   1, 0, 0, 0, 0, 0, 0, 4'b0010, 100, 200, 0, 0, 0, 0);
    step("q_n0", 1, 0, 0, 0, 0, 0, 0, 4'b0000, 100, 201, -1, 2, 0, 0);
    step("q_n1", 1, 0, 0, 0, 0, 0, 0, 4'b0000, 100, 203, -2, 2, 0, 0);
    step("q_n2", 1, 0, 0, 0, 0, 0, 0, 4'b0000, 100, 206, -3, 2, 0, 0);
    step("q_n3", 1, 0, 0, 0, 0, 0, 0, 4'b0000, 100, 210, -4, 2, 0, 0);
    step("q_n4", 1, 0, 0, 0, 1, 0, 0, 4'b0000, 100, 215, -5, 2, 0, 0);

    // Long fall: saturating velocity and bottom clamp
    step("f_spawn", 0, 1, 100, 400, 0, 0, 0, 4'b0000, 100, 400, 0, 2, 0, 0);
    y = 400;
    v = 0;
    for (int i = 0; i < 16; i++) begin
      v = (v - 1 < -8) ? -8 : v - 1;
      y = (y - v > 479) ? 479 : y - v;
      step($sformatf("fall%0d", i), 1, 0, 0, 0, 0, 0, 0, 4'b0000, 100, y, v, 2, 0, 0);
    end
    step("f_land", 1, 0, 0, 0, 0, 0, 0, 4'b0010, 100, 479, 0, 0, 0, 0);

    // Horizontal edges, wall blocking, priority
    step("h_spawn1", 0, 1, 639, 300, 0, 0, 0, 4'b0000, 639, 300, 0, 2, 0, 0);
    step("h_rmax",   1, 0, 0, 0, 0, 0, 1, 4'b0010, 639, 300, 0, 0, 0, 0);
    step("h_spawn2", 0, 1, 5, 300, 0, 0, 0, 4'b0000, 5, 300, 0, 2, 0, 0);
    step("h_lwall",  1, 0, 0, 0, 0, 1, 0, 4'b1010, 5, 300, 0, 0, 1, 0);
    step("h_left",   1, 0, 0, 0, 0, 1, 0, 4'b0010, 4, 300, 0, 0, 1, 1);
    step("h_both",   1, 0, 0, 0, 0, 1, 1, 4'b0010, 3, 300, 0, 0, 1, 1);
    step("h_right",  1, 0, 0, 0, 0, 0, 1, 4'b0010, 4, 300, 0, 0, 0, 1);
    step("h_spawn3", 0, 1, 0, 300, 0, 0, 0, 4'b0000, 0, 300, 0, 2, 0, 0);
    step("h_lmin",   1, 0, 0, 0, 0, 1, 0, 4'b0010, 0, 300, 0, 0, 1, 0);
    step("h_sptick", 1, 1, 50, 60, 1, 0, 0, 4'b0010, 50, 60, 0, 2, 1, 0);

    // Asynchronous reset between edges
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    e = '{tag: "areset", x: 32, y: 400, v: 0, ms: 2, fl: 0, wk: 0};
    check_outputs(e);
    @(negedge clk);
    rst_n = 1'b1;
    step("ar_land", 1, 0, 0, 0, 0, 0, 0, 4'b0010, 32, 400, 0, 0, 0, 0);

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
